// File: rtl/reg_scoreboard_pkg.sv
// Shared core constants and types for the register scoreboard.
package reg_scoreboard_pkg;

    // Architectural register count (x0..x31) and pending-write counter width.
    localparam int NREG   = 32;
    localparam int CNT_W  = 2;
    // Register index width and data path width.
    localparam int IDX_W  = 5;
    localparam int DATA_W = 32;

    typedef logic [IDX_W-1:0]  reg_idx_t;
    typedef logic [DATA_W-1:0] data_t;

    // Contents of the issue output register.
    typedef struct packed {
        data_t    op1;
        data_t    op2;
        reg_idx_t rd;
        logic     rd_write;
    } out_pkt_t;

endpackage

// File: rtl/reg_scoreboard_counter_bank.sv
// Per-register pending-write counters. x0 is hard-wired to zero. Increment and
// decrement hitting the same register in the same cycle cancel; a decrement of
// a zero counter is dropped so the count can never wrap below zero.
module sb_counter_bank
    import reg_scoreboard_pkg::IDX_W;
#(
    parameter int NREG  = reg_scoreboard_pkg::NREG,
    parameter int CNT_W = reg_scoreboard_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_inc_en,
    input  logic [IDX_W-1:0] i_inc_idx,
    input  logic             i_dec_en,
    input  logic [IDX_W-1:0] i_dec_idx,
    input  logic [IDX_W-1:0] i_rd_idx_a,
    input  logic [IDX_W-1:0] i_rd_idx_b,
    input  logic [IDX_W-1:0] i_rd_idx_c,
    output logic [CNT_W-1:0] o_cnt_a,
    output logic [CNT_W-1:0] o_cnt_b,
    output logic [CNT_W-1:0] o_cnt_c
);

    logic [CNT_W-1:0] r_cnt [NREG];
    logic [NREG-1:0]  w_inc;
    logic [NREG-1:0]  w_dec;

    // Decode which register is incremented / decremented this cycle.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 1; i < NREG; i++) begin
            w_inc[i] = i_inc_en && (i_inc_idx == IDX_W'(i));
            w_dec[i] = i_dec_en && (i_dec_idx == IDX_W'(i)) && (r_cnt[i] != '0);
        end
    end

    // Counter update; clear (flush) wins over any increment or decrement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
        end else if (i_clear) begin
            for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
        end else begin
            r_cnt[0] <= '0;
            for (int i = 1; i < NREG; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (w_dec[i] && !w_inc[i]) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    assign o_cnt_a = (i_rd_idx_a == '0) ? '0 : r_cnt[i_rd_idx_a];
    assign o_cnt_b = (i_rd_idx_b == '0) ? '0 : r_cnt[i_rd_idx_b];
    assign o_cnt_c = (i_rd_idx_c == '0) ? '0 : r_cnt[i_rd_idx_c];

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard between decode and execute: tracks pending writes per
// register, stalls issue on RAW hazards, bypasses a same-cycle writeback into
// the operands, and holds the accepted instruction in one output register.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and its payload stable until that edge;
// ready may change freely and never depends combinationally on valid.
// Upstream is iss_valid/iss_ready, downstream is out_valid/out_ready.
module reg_scoreboard
    import reg_scoreboard_pkg::IDX_W, reg_scoreboard_pkg::DATA_W, reg_scoreboard_pkg::out_pkt_t;
#(
    parameter int NREG  = reg_scoreboard_pkg::NREG,
    parameter int CNT_W = reg_scoreboard_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [IDX_W-1:0]  iss_rs1,
    input  logic [IDX_W-1:0]  iss_rs2,
    input  logic              iss_use_rs1,
    input  logic              iss_use_rs2,
    input  logic [IDX_W-1:0]  iss_rd,
    input  logic              iss_rd_write,
    input  logic [DATA_W-1:0] rf_rs1,
    input  logic [DATA_W-1:0] rf_rs2,
    input  logic              wb_valid,
    input  logic [IDX_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [IDX_W-1:0]  out_rd,
    output logic              out_rd_write
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] w_cnt_rs1;
    logic [CNT_W-1:0] w_cnt_rs2;
    logic [CNT_W-1:0] w_cnt_rd;
    logic             w_byp_rs1;
    logic             w_byp_rs2;
    logic             w_free_rs1;
    logic             w_free_rs2;
    logic             w_rd_ok;
    logic             w_out_free;
    logic             w_accept;
    logic             w_inc_en;
    logic             w_dec_en;
    out_pkt_t         w_next;
    out_pkt_t         r_out;
    logic             r_out_valid;

    sb_counter_bank #(
        .NREG  (NREG),
        .CNT_W (CNT_W)
    ) u_bank (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (flush),
        .i_inc_en   (w_inc_en),
        .i_inc_idx  (iss_rd),
        .i_dec_en   (w_dec_en),
        .i_dec_idx  (wb_rd),
        .i_rd_idx_a (iss_rs1),
        .i_rd_idx_b (iss_rs2),
        .i_rd_idx_c (iss_rd),
        .o_cnt_a    (w_cnt_rs1),
        .o_cnt_b    (w_cnt_rs2),
        .o_cnt_c    (w_cnt_rd)
    );

    // Hazard check, bypass detection and operand selection.
    always_comb begin
        // Bypass only when the writeback retires the last outstanding write.
        w_byp_rs1  = wb_valid && (wb_rd == iss_rs1) && (iss_rs1 != '0) && (w_cnt_rs1 == CNT_ONE);
        w_byp_rs2  = wb_valid && (wb_rd == iss_rs2) && (iss_rs2 != '0) && (w_cnt_rs2 == CNT_ONE);
        w_free_rs1 = !iss_use_rs1 || (iss_rs1 == '0) || (w_cnt_rs1 == '0) || w_byp_rs1;
        w_free_rs2 = !iss_use_rs2 || (iss_rs2 == '0) || (w_cnt_rs2 == '0) || w_byp_rs2;
        w_rd_ok    = !iss_rd_write || (w_cnt_rd != CNT_MAX);
        w_out_free = !r_out_valid || out_ready;
        iss_ready  = w_free_rs1 && w_free_rs2 && w_rd_ok && !flush && w_out_free;
        w_accept   = iss_valid && iss_ready;
        w_inc_en   = w_accept && iss_rd_write && (iss_rd != '0);
        w_dec_en   = wb_valid && (wb_rd != '0);

        w_next          = '0;
        w_next.op1      = (iss_rs1 == '0) ? '0 : (w_byp_rs1 ? wb_data : rf_rs1);
        w_next.op2      = (iss_rs2 == '0) ? '0 : (w_byp_rs2 ? wb_data : rf_rs2);
        w_next.rd       = iss_rd;
        w_next.rd_write = iss_rd_write;
    end

    // Output register: load on accept, drop valid on drain, cleared by flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out       <= w_next;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_op1      = r_out.op1;
    assign out_op2      = r_out.op2;
    assign out_rd       = r_out.rd;
    assign out_rd_write = r_out.rd_write;

endmodule
